alu_issue_queue: RTL and testbench

//  Collapsing, oldest-first issue queue feeding the ALU functional units of the OoO core.

---
 rtl/alu_issue_queue_if.sv | 54 +++++
 rtl/alu_issue_queue.sv | 151 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Handshake/bus bundle for alu_issue_queue.
//  slave  : the queue side (takes dispatch, wakeup, fu_ready, flush; drives issue bus)
//  master : the surrounding core / bench side
//  Dispatch : flush, disp_valid/disp_ready, disp_* op fields
//  Wakeup   : wb_valid/wb_tag/wb_data, one lane per ALU, lane i at [i*W +: W]
//  Issue    : fu_ready in, alu_number (one-hot, 0 = idle), optype, data_in_*, dr_in out
//  Status   : count of occupied entries
interface alu_issue_queue_if #(
  parameter int DEPTH   = 8,
  parameter int PREG_W  = 6,
  parameter int ALU_NUM = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                      flush;
  logic                      disp_valid;
  logic                      disp_ready;
  logic [3:0]                disp_optype;
  logic [PREG_W-1:0]         disp_sr1_tag;
  logic                      disp_sr1_rdy;
  logic [31:0]               disp_sr1_val;
  logic [PREG_W-1:0]         disp_sr2_tag;
  logic                      disp_sr2_rdy;
  logic [31:0]               disp_sr2_val;
  logic [31:0]               disp_imm;
  logic [PREG_W-1:0]         disp_dr;
  logic [ALU_NUM-1:0]        wb_valid;
  logic [ALU_NUM*PREG_W-1:0] wb_tag;
  logic [ALU_NUM*32-1:0]     wb_data;
  logic [ALU_NUM-1:0]        fu_ready;
  logic [ALU_NUM-1:0]        alu_number;
  logic [3:0]                optype;
  logic [31:0]               data_in_sr1;
  logic [31:0]               data_in_sr2;
  logic [31:0]               data_in_imm;
  logic [PREG_W-1:0]         dr_in;
  logic [CW-1:0]             count;

  modport slave (
    input  flush, disp_valid, disp_optype, disp_sr1_tag, disp_sr1_rdy, disp_sr1_val,
           disp_sr2_tag, disp_sr2_rdy, disp_sr2_val, disp_imm, disp_dr,
           wb_valid, wb_tag, wb_data, fu_ready,
    output disp_ready, alu_number, optype, data_in_sr1, data_in_sr2, data_in_imm,
           dr_in, count
  );

  modport master (
    output flush, disp_valid, disp_optype, disp_sr1_tag, disp_sr1_rdy, disp_sr1_val,
           disp_sr2_tag, disp_sr2_rdy, disp_sr2_val, disp_imm, disp_dr,
           wb_valid, wb_tag, wb_data, fu_ready,
    input  disp_ready, alu_number, optype, data_in_sr1, data_in_sr2, data_in_imm,
           dr_in, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Collapsing, oldest-first ALU issue queue.
//  clk, rstn : clock, asynchronous active-low reset
//  io        : alu_issue_queue_if.slave (dispatch, wakeup lanes, fu_ready, issue bus, count)
// Slots 0..count-1 hold valid ops, slot 0 oldest. Validity is derived from count,
// so the collapse only has to move payloads. One op issues per cycle, registered.
module alu_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int PREG_W  = 6,
  parameter int ALU_NUM = 3
) (
  input  logic             clk,
  input  logic             rstn,
  alu_issue_queue_if.slave io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [3:0]        op;
    logic [PREG_W-1:0] t1;
    logic              r1;
    logic [31:0]       v1;
    logic [PREG_W-1:0] t2;
    logic              r2;
    logic [31:0]       v2;
    logic [31:0]       imm;
    logic [PREG_W-1:0] dr;
  } entry_t;

  // Capture any matching broadcast into a not-yet-ready source. Lanes are
  // scanned high to low so the lowest matching lane is the final writer.
  function automatic entry_t wake(input entry_t e,
                                  input logic [ALU_NUM-1:0]        v,
                                  input logic [ALU_NUM*PREG_W-1:0] t,
                                  input logic [ALU_NUM*32-1:0]     d);
    entry_t r;
    r = e;
    for (int l = ALU_NUM - 1; l >= 0; l--) begin
      if (v[l] && !e.r1 && t[l*PREG_W +: PREG_W] == e.t1) begin
        r.r1 = 1'b1;
        r.v1 = d[l*32 +: 32];
      end
      if (v[l] && !e.r2 && t[l*PREG_W +: PREG_W] == e.t2) begin
        r.r2 = 1'b1;
        r.v2 = d[l*32 +: 32];
      end
    end
    return r;
  endfunction

  entry_t [DEPTH-1:0] q;
  logic   [CW-1:0]    cnt;

  logic [ALU_NUM-1:0] iss_alu;
  logic [3:0]         iss_op;
  logic [31:0]        iss_s1, iss_s2, iss_imm;
  logic [PREG_W-1:0]  iss_dr;

  entry_t             disp_e, disp_w;
  entry_t [DEPTH:0]   ext;      // woken entries plus an empty slot shifted in at the top
  entry_t [DEPTH-1:0] nxt;
  logic [DEPTH-1:0]   issuable;
  logic               sel_any, do_issue, accept;
  logic [IW-1:0]      sel_idx;
  logic [ALU_NUM-1:0] fu_oh;
  logic [CW-1:0]      wr_slot;

  assign disp_e = '{op: io.disp_optype, t1: io.disp_sr1_tag, r1: io.disp_sr1_rdy,
                    v1: io.disp_sr1_val, t2: io.disp_sr2_tag, r2: io.disp_sr2_rdy,
                    v2: io.disp_sr2_val, imm: io.disp_imm, dr: io.disp_dr};
  assign disp_w = wake(disp_e, io.wb_valid, io.wb_tag, io.wb_data);

  // Readiness is judged on registered state only: a value woken at this edge
  // becomes issuable next cycle.
  always_comb begin
    ext = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ext[k]      = wake(q[k], io.wb_valid, io.wb_tag, io.wb_data);
      issuable[k] = (CW'(k) < cnt) && q[k].r1 && q[k].r2;
    end
  end

  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (issuable[k]) begin
        sel_any = 1'b1;
        sel_idx = IW'(k);
      end
    end
    fu_oh = '0;
    for (int i = ALU_NUM - 1; i >= 0; i--) begin
      if (io.fu_ready[i]) begin
        fu_oh    = '0;
        fu_oh[i] = 1'b1;
      end
    end
  end

  assign do_issue = sel_any && (|io.fu_ready);
  // Full blocks dispatch even if a slot frees this same cycle.
  assign accept   = io.disp_valid && (cnt < CW'(DEPTH));
  // Dispatch lands behind the survivors, keeping age order across the collapse.
  assign wr_slot  = cnt - CW'(do_issue);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      if (do_issue && IW'(k) >= sel_idx) nxt[k] = ext[k+1];
      else                               nxt[k] = ext[k];
      if (accept && CW'(k) == wr_slot)   nxt[k] = disp_w;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q       <= '0;
      cnt     <= '0;
      iss_alu <= '0;
      iss_op  <= '0;
      iss_s1  <= '0;
      iss_s2  <= '0;
      iss_imm <= '0;
      iss_dr  <= '0;
    end else if (io.flush) begin
      // Payloads and data outputs are left stale; count alone defines validity.
      cnt     <= '0;
      iss_alu <= '0;
    end else begin
      q       <= nxt;
      cnt     <= cnt + CW'(accept) - CW'(do_issue);
      iss_alu <= do_issue ? fu_oh : '0;
      if (do_issue) begin
        iss_op  <= q[sel_idx].op;
        iss_s1  <= q[sel_idx].v1;
        iss_s2  <= q[sel_idx].v2;
        iss_imm <= q[sel_idx].imm;
        iss_dr  <= q[sel_idx].dr;
      end
    end
  end

  assign io.disp_ready  = cnt < CW'(DEPTH);
  assign io.count       = cnt;
  assign io.alu_number  = iss_alu;
  assign io.optype      = iss_op;
  assign io.data_in_sr1 = iss_s1;
  assign io.data_in_sr2 = iss_s2;
  assign io.data_in_imm = iss_imm;
  assign io.dr_in       = iss_dr;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed vector table, hand sequences
// for the multi-cycle corners, and a randomized run against a queue-based model.
module tb_alu_issue_queue;
  localparam int DEPTH = 8, PREG_W = 6, ALU_NUM = 3;

  logic clk, rstn;
  int   n_tests, n_fail, cyc;

  alu_issue_queue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ALU_NUM(ALU_NUM)) bus ();
  alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ALU_NUM(ALU_NUM))
    dut (.clk(clk), .rstn(rstn), .io(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  op;
    logic [5:0]  t1, t2, dr;
    logic        r1, r2;
    logic [31:0] v1, v2, imm;
  } ment_t;

  ment_t       mq[$];
  logic [2:0]  m_alu;
  logic [3:0]  m_op;
  logic [31:0] m_s1, m_s2, m_imm;
  logic [5:0]  m_dr;
  bit          m_dv;   // data outputs are defined (not after a flush)

  function automatic ment_t mwake(input ment_t e);
    logic [5:0]  tg;
    logic [31:0] d;
    for (int l = 0; l < ALU_NUM; l++) begin
      if (bus.wb_valid[l]) begin
        tg = bus.wb_tag[l*PREG_W +: PREG_W];
        d  = bus.wb_data[l*32 +: 32];
        if (!e.r1 && tg == e.t1) begin e.r1 = 1'b1; e.v1 = d; end
        if (!e.r2 && tg == e.t2) begin e.r2 = 1'b1; e.v2 = d; end
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_alu = '0; m_op = '0; m_s1 = '0; m_s2 = '0; m_imm = '0; m_dr = '0;
    m_dv = 1'b1;
  endtask

  task automatic model_eval();
    int sel, fu, sz0;
    ment_t ne;
    sel = -1; fu = -1;
    if (bus.flush) begin
      mq.delete(); m_alu = '0; m_dv = 1'b0;
      return;
    end
    sz0 = mq.size();
    foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    for (int i = 0; i < ALU_NUM; i++) if (fu < 0 && bus.fu_ready[i]) fu = i;
    m_alu = '0;
    if (sel >= 0 && fu >= 0) begin
      m_alu[fu] = 1'b1;
      m_op = mq[sel].op; m_s1 = mq[sel].v1; m_s2 = mq[sel].v2;
      m_imm = mq[sel].imm; m_dr = mq[sel].dr; m_dv = 1'b1;
      mq.delete(sel);
    end
    foreach (mq[i]) mq[i] = mwake(mq[i]);
    if (bus.disp_valid && sz0 < DEPTH) begin
      ne.op = bus.disp_optype; ne.t1 = bus.disp_sr1_tag; ne.r1 = bus.disp_sr1_rdy;
      ne.v1 = bus.disp_sr1_val; ne.t2 = bus.disp_sr2_tag; ne.r2 = bus.disp_sr2_rdy;
      ne.v2 = bus.disp_sr2_val; ne.imm = bus.disp_imm; ne.dr = bus.disp_dr;
      mq.push_back(mwake(ne));
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    chk("m_alu_number", 32'(bus.alu_number), 32'(m_alu));
    chk("m_count", 32'(bus.count), mq.size());
    chk("m_disp_ready", 32'(bus.disp_ready), 32'(mq.size() < DEPTH));
    if (m_dv) begin
      chk("m_optype", 32'(bus.optype), 32'(m_op));
      chk("m_sr1", bus.data_in_sr1, m_s1);
      chk("m_sr2", bus.data_in_sr2, m_s2);
      chk("m_imm", bus.data_in_imm, m_imm);
      chk("m_dr", 32'(bus.dr_in), 32'(m_dr));
    end
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.wb_valid = '0;
  endtask

  task automatic disp(input int op, input int t1, input bit r1, input logic [31:0] v1,
                      input int t2, input bit r2, input logic [31:0] v2,
                      input logic [31:0] imm, input int dr);
    bus.disp_valid = 1'b1; bus.disp_optype = 4'(op);
    bus.disp_sr1_tag = 6'(t1); bus.disp_sr1_rdy = r1; bus.disp_sr1_val = v1;
    bus.disp_sr2_tag = 6'(t2); bus.disp_sr2_rdy = r2; bus.disp_sr2_val = v2;
    bus.disp_imm = imm; bus.disp_dr = 6'(dr);
  endtask

  task automatic wb(input int lane, input int tag, input logic [31:0] data);
    bus.wb_valid[lane] = 1'b1;
    bus.wb_tag[lane*PREG_W +: PREG_W] = 6'(tag);
    bus.wb_data[lane*32 +: 32] = data;
  endtask

  // One clock: model sees the same inputs as the DUT, outputs compared #1 after the edge.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    model_check();
    idle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit dv; int op, t1; bit r1; logic [31:0] v1; bit r2; logic [31:0] v2, imm; int dr;
    logic [2:0] fu; int wbl, wbt; logic [31:0] wbd;
    logic [2:0] e_alu; logic [3:0] e_op; logic [31:0] e_s1, e_s2, e_imm; int e_dr, e_cnt;
  } vec_t;

  function automatic vec_t mkv(int dv, int op, int t1, int r1, int v1, int r2, int v2,
                               int imm, int dr, int fu, int wbl, int wbt, int wbd,
                               int e_alu, int e_op, int e_s1, int e_s2, int e_imm,
                               int e_dr, int e_cnt);
    vec_t v;
    v.dv = dv[0]; v.op = op; v.t1 = t1; v.r1 = r1[0]; v.v1 = 32'(v1); v.r2 = r2[0];
    v.v2 = 32'(v2); v.imm = 32'(imm); v.dr = dr; v.fu = 3'(fu); v.wbl = wbl;
    v.wbt = wbt; v.wbd = 32'(wbd); v.e_alu = 3'(e_alu); v.e_op = 4'(e_op);
    v.e_s1 = 32'(e_s1); v.e_s2 = 32'(e_s2); v.e_imm = 32'(e_imm);
    v.e_dr = e_dr; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vt[10];

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    //          dv op t1 r1 v1   r2 v2 imm dr  fu wbl wbt wbd      alu op s1      s2 imm dr cnt
    vt[0] = mkv(1, 1, 1, 1, 5,   1, 7, 0,  10, 7, -1, 0,  0,       0,  0, 0,      0, 0,  0, 1);
    vt[1] = mkv(0, 0, 0, 0, 0,   0, 0, 0,  0,  7, -1, 0,  0,       1,  1, 5,      7, 0, 10, 0);
    vt[2] = mkv(1, 2, 12,0, 0,   1, 0, 4,  11, 7, -1, 0,  0,       0,  1, 5,      7, 0, 10, 1);
    vt[3] = mkv(0, 0, 0, 0, 0,   0, 0, 0,  0,  7, -1, 0,  0,       0,  1, 5,      7, 0, 10, 1);
    vt[4] = mkv(0, 0, 0, 0, 0,   0, 0, 0,  0,  7,  1, 12, 100,     0,  1, 5,      7, 0, 10, 1);
    vt[5] = mkv(0, 0, 0, 0, 0,   0, 0, 0,  0,  7, -1, 0,  0,       1,  2, 100,    0, 4, 11, 0);
    vt[6] = mkv(1, 1, 20,0, 0,   1, 3, 0,  12, 7,  0, 20, 'hDEAD,  0,  2, 100,    0, 4, 11, 1);
    vt[7] = mkv(0, 0, 0, 0, 0,   0, 0, 0,  0,  7, -1, 0,  0,       1,  1, 'hDEAD, 3, 0, 12, 0);
    vt[8] = mkv(1, 9, 0, 1, 1,   1, 2, 8,  13, 6, -1, 0,  0,       0,  1, 'hDEAD, 3, 0, 12, 1);
    vt[9] = mkv(0, 0, 0, 0, 0,   0, 0, 0,  0,  6, -1, 0,  0,       2,  9, 1,      2, 8, 13, 0);

    // reset
    rstn = 1'b0; bus.fu_ready = '0; bus.wb_tag = '0; bus.wb_data = '0;
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0); idle();
    model_reset();
    #12;
    chk("rst_alu_number", 32'(bus.alu_number), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_optype", 32'(bus.optype), 0);
    chk("rst_sr1", bus.data_in_sr1, 0);
    chk("rst_dr", 32'(bus.dr_in), 0);
    chk("rst_disp_ready", 32'(bus.disp_ready), 1);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 10; r++) begin
      bus.fu_ready = vt[r].fu;
      if (vt[r].dv)
        disp(vt[r].op, vt[r].t1, vt[r].r1, vt[r].v1, 0, vt[r].r2, vt[r].v2, vt[r].imm, vt[r].dr);
      if (vt[r].wbl >= 0) wb(vt[r].wbl, vt[r].wbt, vt[r].wbd);
      step();
      chk($sformatf("vec%0d_alu", r), 32'(bus.alu_number), 32'(vt[r].e_alu));
      chk($sformatf("vec%0d_op", r), 32'(bus.optype), 32'(vt[r].e_op));
      chk($sformatf("vec%0d_sr1", r), bus.data_in_sr1, vt[r].e_s1);
      chk($sformatf("vec%0d_sr2", r), bus.data_in_sr2, vt[r].e_s2);
      chk($sformatf("vec%0d_imm", r), bus.data_in_imm, vt[r].e_imm);
      chk($sformatf("vec%0d_dr", r), 32'(bus.dr_in), vt[r].e_dr);
      chk($sformatf("vec%0d_cnt", r), 32'(bus.count), vt[r].e_cnt);
    end

    // fill to full with no FU, then drain in order through ALU2
    bus.fu_ready = 3'b000;
    for (int i = 0; i < DEPTH; i++) begin
      disp(1 + i % 9, 0, 1, 32'(i), 0, 1, 32'(i * 3), 0, 20 + i);
      step();
    end
    chk("full_count", 32'(bus.count), DEPTH);
    chk("full_disp_ready", 32'(bus.disp_ready), 0);
    chk("full_alu", 32'(bus.alu_number), 0);
    bus.fu_ready = 3'b100;
    for (int i = 0; i < DEPTH; i++) begin
      // dispatch attempted while full and issuing: must be refused
      if (i == 0) disp(1, 0, 1, 0, 0, 1, 0, 0, 63);
      step();
      chk($sformatf("drain%0d_alu", i), 32'(bus.alu_number), 32'b100);
      chk($sformatf("drain%0d_dr", i), 32'(bus.dr_in), 20 + i);
      chk($sformatf("drain%0d_cnt", i), 32'(bus.count), DEPTH - 1 - i);
    end
    step();
    chk("drain_end_alu", 32'(bus.alu_number), 0);

    // out-of-order issue across the collapse: A(wait 30), B(ready), C(wait 31)
    bus.fu_ready = 3'b111;
    disp(2, 30, 0, 0, 0, 1, 0, 1, 40); step();
    disp(1, 0, 1, 9, 0, 1, 9, 0, 41);  step();
    disp(2, 31, 0, 0, 0, 1, 0, 2, 42); step();
    chk("ooo_b_alu", 32'(bus.alu_number), 1);
    chk("ooo_b_dr", 32'(bus.dr_in), 41);
    chk("ooo_b_cnt", 32'(bus.count), 2);
    wb(0, 31, 32'h31); step();
    chk("ooo_wait_alu", 32'(bus.alu_number), 0);
    step();
    chk("ooo_c_dr", 32'(bus.dr_in), 42);
    chk("ooo_c_sr1", bus.data_in_sr1, 32'h31);
    wb(2, 30, 32'h30); step();
    step();
    chk("ooo_a_dr", 32'(bus.dr_in), 40);
    chk("ooo_a_sr1", bus.data_in_sr1, 32'h30);
    chk("ooo_end_cnt", 32'(bus.count), 0);

    // flush with a dispatch and ready FUs in the same cycle
    bus.fu_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin disp(1, 0, 1, 1, 0, 1, 1, 0, i); step(); end
    bus.fu_ready = 3'b111;
    bus.flush = 1'b1; disp(1, 0, 1, 1, 0, 1, 1, 0, 7); step();
    chk("flush_cnt", 32'(bus.count), 0);
    chk("flush_alu", 32'(bus.alu_number), 0);
    chk("flush_ready", 32'(bus.disp_ready), 1);
    step();
    chk("flush_after_alu", 32'(bus.alu_number), 0);

    // asynchronous reset mid-cycle
    bus.fu_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin disp(3, 0, 1, 2, 0, 1, 2, 0, i); step(); end
    bus.fu_ready = 3'b111;
    disp(1, 0, 1, 77, 0, 1, 0, 0, 5); step();   // leaves nonzero data on the outputs
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt", 32'(bus.count), 0);
    chk("arst_alu", 32'(bus.alu_number), 0);
    chk("arst_sr1", bus.data_in_sr1, 0);
    chk("arst_ready", 32'(bus.disp_ready), 1);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    disp(4, 0, 1, 8, 0, 1, 9, 3, 6); step();
    step();
    chk("arst_resume_dr", 32'(bus.dr_in), 6);

    // randomized run against the model
    for (int c = 0; c < 600; c++) begin
      bus.fu_ready = 3'($urandom);
      if ($urandom_range(2, 0) != 0)
        disp($urandom_range(9, 1), $urandom_range(7, 0), 1'($urandom), $urandom,
             $urandom_range(7, 0), 1'($urandom), $urandom, $urandom, $urandom_range(63, 0));
      for (int l = 0; l < ALU_NUM; l++) begin
        int tg;
        tg = $urandom_range(7, 0);
        if ($urandom_range(1, 0) == 1) wb(l, tg, (32'(tg) * 32'h01010101) ^ (32'(c) * 32'h9E37));
      end
      if ($urandom_range(49, 0) == 0) bus.flush = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
